// File: rtl/rpn_eval_if.sv
// Token, stack and result signals of the RPN evaluator, bundled as one interface.
// The master side is the evaluator; the slave side is the token source, stack and result sink.
interface rpn_eval_if;
  logic       tok_valid;
  logic       tok_op;
  logic [7:0] tok_data;
  logic       tok_ready;
  logic       clear;
  logic [7:0] stk_data;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_q;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_error;
  logic [7:0] res_data;
  logic       res_valid;
  logic       err;
  logic [2:0] err_code;

  modport master (
    input  tok_valid, tok_op, tok_data, clear, stk_q, stk_full, stk_empty, stk_error,
    output tok_ready, stk_data, stk_push, stk_pop, res_data, res_valid, err, err_code
  );

  modport slave (
    output tok_valid, tok_op, tok_data, clear, stk_q, stk_full, stk_empty, stk_error,
    input  tok_ready, stk_data, stk_push, stk_pop, res_data, res_valid, err, err_code
  );
endinterface

// File: rtl/rpn_eval.sv
// Reverse-Polish evaluator: sole master of an 8-bit LIFO with RD_LAT-cycle pop latency.
// Operands are pushed, operators pop B then A and push the 8-bit result; faults park in ERR.
module rpn_eval #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic      clock,
  input  logic      reset_n,
  rpn_eval_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, PUSH_N, POP_B, WAIT_B, POP_A, WAIT_A, EXEC, PUSH_R, EMIT, ERR
  } state_e;

  localparam logic [2:0] OP_ILL   = 3'd6;
  localparam logic [2:0] OP_OUT   = 3'd7;
  localparam logic [2:0] E_OVF    = 3'd1;
  localparam logic [2:0] E_UNF    = 3'd2;
  localparam logic [2:0] E_FAULT  = 3'd3;
  localparam logic [2:0] E_ILLOP  = 3'd4;
  localparam bit         NO_WAIT  = (RD_LAT == 1);
  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e     state_q, state_d;
  logic [2:0] err_code_q, err_code_d;
  logic [7:0] res_data_q, res_data_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] tok_q;
  logic [7:0] b_q;

  logic       tok_ready, stk_push, stk_pop, res_valid, err;
  logic [7:0] stk_data, res_data;
  logic       is_out;

  function automatic logic [7:0] alu(input logic [2:0] opc,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    case (opc)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return prod[7:0];
      default: return 8'd0;
    endcase
  endfunction

  assign is_out = (tok_q[2:0] == OP_OUT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      err_code_q <= 3'd0;
      res_data_q <= 8'd0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      res_data_q <= res_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // B arrives on stk_q during POP_A, RD_LAT cycles after its own pop.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && bus.tok_valid) tok_q <= bus.tok_data;
    if (state_q == POP_A) b_q <= bus.stk_q;
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    res_data_d = res_data_q;
    cnt_d      = 2'd0;
    if (state_q != IDLE && state_q != ERR && bus.stk_error) begin
      state_d    = ERR;
      err_code_d = E_FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.tok_valid) begin
            if (!bus.tok_op) begin
              state_d = PUSH_N;
            end else if (bus.tok_data[2:0] == OP_ILL) begin
              state_d    = ERR;
              err_code_d = E_ILLOP;
            end else begin
              state_d = POP_B;
            end
          end
        end
        PUSH_N: begin
          if (bus.stk_full) begin
            state_d    = ERR;
            err_code_d = E_OVF;
          end else begin
            state_d = IDLE;
          end
        end
        POP_B: begin
          if (bus.stk_empty) begin
            state_d    = ERR;
            err_code_d = E_UNF;
          end else if (NO_WAIT) begin
            state_d = is_out ? EMIT : POP_A;
          end else begin
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (cnt_q == WAIT_LAST) state_d = is_out ? EMIT : POP_A;
          else                    cnt_d   = 2'(cnt_q + 2'd1);
        end
        POP_A: begin
          if (bus.stk_empty) begin
            state_d    = ERR;
            err_code_d = E_UNF;
          end else begin
            state_d = NO_WAIT ? EXEC : WAIT_A;
          end
        end
        WAIT_A: begin
          if (cnt_q == WAIT_LAST) state_d = EXEC;
          else                    cnt_d   = 2'(cnt_q + 2'd1);
        end
        EXEC: begin
          res_data_d = alu(tok_q[2:0], bus.stk_q, b_q);
          state_d    = PUSH_R;
        end
        PUSH_R: state_d = IDLE;
        EMIT: begin
          res_data_d = bus.stk_q;
          state_d    = IDLE;
        end
        ERR: begin
          if (bus.clear) begin
            state_d    = IDLE;
            err_code_d = 3'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes and result pulses are suppressed in any cycle that flags a stack fault.
  always_comb begin
    tok_ready = (state_q == IDLE) && reset_n;
    err       = (state_q == ERR);
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_data  = 8'd0;
    res_valid = 1'b0;
    res_data  = res_data_q;
    case (state_q)
      PUSH_N: begin
        if (!bus.stk_error && !bus.stk_full) begin
          stk_push = 1'b1;
          stk_data = tok_q;
        end
      end
      POP_B, POP_A: stk_pop = !bus.stk_error && !bus.stk_empty;
      PUSH_R: begin
        if (!bus.stk_error) begin
          stk_push  = 1'b1;
          stk_data  = res_data_q;
          res_valid = 1'b1;
        end
      end
      EMIT: begin
        res_data  = bus.stk_q;
        res_valid = !bus.stk_error;
      end
      default: ;
    endcase
  end

  assign bus.tok_ready = tok_ready;
  assign bus.stk_push  = stk_push;
  assign bus.stk_pop   = stk_pop;
  assign bus.stk_data  = stk_data;
  assign bus.res_data  = res_data;
  assign bus.res_valid = res_valid;
  assign bus.err       = err;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_rpn_eval.sv
// Bench for rpn_eval: behavioural LIFO with pop latency plus a queue-based RPN reference model.
module tb_rpn_eval;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  rpn_eval_if bus();

  rpn_eval #(.RD_LAT(RD_LAT)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Stack model: flags follow the previous strobe, popped word appears RD_LAT cycles later.
  logic [7:0] mem [DEPTH];
  logic [7:0] pipe [4];
  int         sp = 0;
  logic       stk_clr = 1'b0;
  logic       err_force = 1'b0;

  always @(posedge clk) begin
    for (int i = 3; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= 8'hA5;
    if (stk_clr) begin
      sp <= 0;
    end else if (bus.stk_push && sp < DEPTH) begin
      mem[sp] <= bus.stk_data;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      pipe[0] <= mem[sp-1];
      sp      <= sp - 1;
    end
  end

  assign bus.stk_q     = pipe[RD_LAT-1];
  assign bus.stk_full  = (sp >= DEPTH);
  assign bus.stk_empty = (sp == 0);
  assign bus.stk_error = err_force;

  // Event monitor, sampled on the falling edge.
  int         cyc = 0;
  int         n_push = 0, n_pop = 0, n_res = 0, n_excl = 0, n_hold = 0;
  int         push_cyc = 0, res_cyc = 0;
  logic [7:0] last_push = 8'd0, last_res = 8'd0;
  logic       prev_push = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_push <= bus.stk_push;
    if (bus.stk_push) begin
      n_push    <= n_push + 1;
      last_push <= bus.stk_data;
      push_cyc  <= cyc;
      if (prev_push) n_hold <= n_hold + 1;
    end
    if (bus.stk_pop) n_pop <= n_pop + 1;
    if (bus.stk_push && bus.stk_pop) n_excl <= n_excl + 1;
    if (bus.res_valid) begin
      n_res    <= n_res + 1;
      last_res <= bus.res_data;
      res_cyc  <= cyc;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the expected stack contents as a plain queue.
  logic [7:0] ref_stk[$];

  function automatic logic [7:0] ref_op(input logic [2:0] opc,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (opc)
      3'd0:    r = ia + ib;
      3'd1:    r = ia - ib + 256;
      3'd2:    r = ia & ib;
      3'd3:    r = ia | ib;
      3'd4:    r = ia ^ ib;
      3'd5:    r = ia * ib;
      default: r = 0;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic accept(input bit op, input logic [7:0] d, output int acc);
    int w = 0;
    while (!bus.tok_ready && w < 50) begin
      tick();
      w++;
    end
    if (!bus.tok_ready) chk("ready_timeout", 0, 1);
    bus.tok_valid = 1'b1;
    bus.tok_op    = op;
    bus.tok_data  = d;
    tick();
    acc           = cyc;
    bus.tok_valid = 1'b0;
    bus.tok_op    = 1'($urandom);
    bus.tok_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    int w = 0;
    while (!bus.tok_ready && !bus.err && w < 60) begin
      tick();
      w++;
    end
    if (!bus.tok_ready && !bus.err) chk("done_timeout", 0, 1);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_err", int'(bus.err), 0);
    chk("clr_code", int'(bus.err_code), 0);
    chk("clr_ready", int'(bus.tok_ready), 1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    stk_clr = 1'b1;
    ref_stk.delete();
    tick();
    tick();
    stk_clr = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("rst_ready", int'(bus.tok_ready), 1);
  endtask

  task automatic run_token(input bit op, input logic [7:0] d);
    int         e_push, e_pop, e_res, e_code, acc;
    int         p0, q0, r0;
    logic [7:0] e_val, a, b;
    e_push = 0; e_pop = 0; e_res = 0; e_code = 0; e_val = 8'd0;
    if (!op) begin
      if (ref_stk.size() >= DEPTH) e_code = 1;
      else begin
        ref_stk.push_back(d);
        e_push = 1;
        e_val  = d;
      end
    end else if (d[2:0] == 3'd6) begin
      e_code = 4;
    end else if (ref_stk.size() == 0) begin
      e_code = 2;
    end else begin
      b     = ref_stk.pop_back();
      e_pop = 1;
      if (d[2:0] == 3'd7) begin
        e_res = 1;
        e_val = b;
      end else if (ref_stk.size() == 0) begin
        e_code = 2;
      end else begin
        a     = ref_stk.pop_back();
        e_pop = 2;
        e_val = ref_op(d[2:0], a, b);
        ref_stk.push_back(e_val);
        e_push = 1;
        e_res  = 1;
      end
    end
    p0 = n_push; q0 = n_pop; r0 = n_res;
    accept(op, d, acc);
    wait_done();
    chk("push_cnt", n_push - p0, e_push);
    chk("pop_cnt", n_pop - q0, e_pop);
    chk("res_cnt", n_res - r0, e_res);
    if (e_res != 0) chk("res_data", int'(last_res), int'(e_val));
    if (e_push != 0) chk("push_data", int'(last_push), int'(e_val));
    if (e_push != 0 && !op) chk("operand_lat", push_cyc - acc, 0);
    if (e_push != 0 && op) chk("binop_lat", push_cyc - acc, 1 + 2 * RD_LAT);
    if (e_res != 0 && e_push == 0) chk("out_lat", res_cyc - acc, RD_LAT);
    chk("err", int'(bus.err), int'(e_code != 0));
    chk("err_code", int'(bus.err_code), e_code);
    if (e_code != 0) begin
      chk("err_ready", int'(bus.tok_ready), 0);
      do_clear();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         acc, p0, q0;
    logic [7:0] d;
    logic [2:0] opc;
    bus.tok_valid = 1'b0;
    bus.tok_op    = 1'b0;
    bus.tok_data  = 8'd0;
    bus.clear     = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tok_ready", int'(bus.tok_ready), 0);
    chk("rst_push", int'(bus.stk_push), 0);
    chk("rst_pop", int'(bus.stk_pop), 0);
    chk("rst_res", int'({bus.res_valid, bus.res_data}), 0);
    chk("rst_err", int'({bus.err, bus.err_code}), 0);
    chk("rst_stk_data", int'(bus.stk_data), 0);
    do_reset();

    // Simple add and wrap-around arithmetic
    run_token(1'b0, 8'd3);
    run_token(1'b0, 8'd4);
    run_token(1'b1, 8'd0);
    chk("add_result", int'(last_res), 7);
    run_token(1'b0, 8'h10);
    run_token(1'b0, 8'h20);
    run_token(1'b1, 8'd1);
    chk("sub_wrap", int'(last_res), 8'hF0);
    run_token(1'b0, 8'h20);
    run_token(1'b0, 8'h10);
    run_token(1'b1, 8'd5);
    chk("mul_wrap", int'(last_res), 0);

    // Underflow after a single B pop
    do_reset();
    run_token(1'b0, 8'd5);
    run_token(1'b1, 8'd0);

    // Overflow, then OUT of the last pushed value
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_token(1'b0, 8'($urandom));
    chk("full_flag", int'(bus.stk_full), 1);
    run_token(1'b0, 8'hEE);
    p0 = n_push;
    run_token(1'b1, 8'd7);
    chk("out_no_push", n_push - p0, 0);

    // Illegal opcode and stack fault during WAIT_B
    run_token(1'b1, 8'd6);
    void'(ref_stk.pop_back());
    p0 = n_push; q0 = n_pop;
    accept(1'b1, 8'd0, acc);
    tick();
    err_force = 1'b1;
    tick();
    err_force = 1'b0;
    wait_done();
    chk("fault_pops", n_pop - q0, 1);
    chk("fault_push", n_push - p0, 0);
    chk("fault_code", int'(bus.err_code), 3);
    do_clear();

    // Reset asserted during WAIT_A
    run_token(1'b0, 8'h21);
    run_token(1'b0, 8'h43);
    accept(1'b1, 8'd4, acc);
    for (int i = 0; i < RD_LAT + 1; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_tok_ready", int'(bus.tok_ready), 0);
    chk("mid_strobes", int'({bus.stk_push, bus.stk_pop, bus.res_valid}), 0);
    chk("mid_res_data", int'(bus.res_data), 0);
    chk("mid_err", int'({bus.err, bus.err_code}), 0);
    do_reset();
    run_token(1'b0, 8'h5A);

    // Randomized token stream
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        run_token(1'b0, 8'($urandom));
      end else begin
        opc = 3'($urandom_range(0, 6));
        if (opc == 3'd6) opc = 3'd7;
        if ($urandom_range(0, 19) == 0) opc = 3'd6;
        d = {5'($urandom), opc};
        run_token(1'b1, d);
      end
    end

    chk("exclusive_strobes", n_excl, 0);
    chk("push_single_cycle", n_hold, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
